// File: rtl/cordic_rotator_pkg.sv
// Shared constants for the CORDIC rotator: FSM encoding, arctangent table and gain constant.
// CORDIC_GAIN_COMP_EN enables the post-rotation gain-compensation multiply.
package cordic_rotator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_SCALE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // 1/gain in Q1.31 (0.6072529)
  localparam logic signed [31:0] GAIN_K = 32'sh4DBA76D4;

  // atan(2^-i) in turn units where 2^32 is one full turn
  function automatic logic [31:0] atan_entry(input logic [4:0] idx);
    logic [31:0] val_s;
    case (idx)
      5'd0:    val_s = 32'h20000000;
      5'd1:    val_s = 32'h12E4051E;
      5'd2:    val_s = 32'h09FB385B;
      5'd3:    val_s = 32'h051111D4;
      5'd4:    val_s = 32'h028B0D43;
      5'd5:    val_s = 32'h0145D7E1;
      5'd6:    val_s = 32'h00A2F61E;
      5'd7:    val_s = 32'h00517C55;
      5'd8:    val_s = 32'h0028BE53;
      5'd9:    val_s = 32'h00145F2F;
      5'd10:   val_s = 32'h000A2F98;
      5'd11:   val_s = 32'h000517CC;
      5'd12:   val_s = 32'h00028BE6;
      5'd13:   val_s = 32'h000145F3;
      5'd14:   val_s = 32'h0000A2FA;
      5'd15:   val_s = 32'h0000517D;
      5'd16:   val_s = 32'h000028BE;
      5'd17:   val_s = 32'h0000145F;
      5'd18:   val_s = 32'h00000A30;
      5'd19:   val_s = 32'h00000518;
      5'd20:   val_s = 32'h0000028C;
      5'd21:   val_s = 32'h00000146;
      5'd22:   val_s = 32'h000000A3;
      5'd23:   val_s = 32'h00000051;
      5'd24:   val_s = 32'h00000029;
      5'd25:   val_s = 32'h00000014;
      5'd26:   val_s = 32'h0000000A;
      5'd27:   val_s = 32'h00000005;
      5'd28:   val_s = 32'h00000003;
      5'd29:   val_s = 32'h00000001;
      5'd30:   val_s = 32'h00000001;
      default: val_s = 32'h00000000;
    endcase
    return val_s;
  endfunction

  // Q1.31 multiply by GAIN_K; bits [62:31] of the full signed product
  function automatic logic signed [31:0] gain_scale(input logic signed [31:0] v);
    logic signed [63:0] prod_s;
    prod_s = $signed({{32{v[31]}}, v}) * $signed({{32{GAIN_K[31]}}, GAIN_K});
    return prod_s[62:31];
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup: iteration index to angle in turn units.
module cordic_atan_lut
  import cordic_rotator_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [31:0] angle
);

  assign angle = atan_entry(idx);

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC vector rotator, one micro-rotation per cycle, valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain.
module cordic_rotator
  import cordic_rotator_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] angle_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] angle_out,
  output logic        busy
);

  localparam logic [5:0] ITER_LAST = 6'(ITER);

  state_t             state_r;
  logic [5:0]         i_r;
  logic signed [31:0] x_r, y_r, z_r;
  logic signed [31:0] x_next_s, y_next_s, z_next_s;
  logic signed [31:0] x_sh_s, y_sh_s;
  logic [31:0]        atan_s;

  cordic_atan_lut u_atan_lut (
    .idx   (i_r[4:0]),
    .angle (atan_s)
  );

  // One micro-rotation; direction chosen by the sign of the residual angle
  always_comb begin
    x_sh_s = x_r >>> i_r;
    y_sh_s = y_r >>> i_r;
    if (z_r[31] == 1'b0) begin
      x_next_s = x_r - y_sh_s;
      y_next_s = y_r + x_sh_s;
      z_next_s = z_r - atan_s;
    end else begin
      x_next_s = x_r + y_sh_s;
      y_next_s = y_r - x_sh_s;
      z_next_s = z_r + atan_s;
    end
  end

  // Control FSM and datapath registers; results are registered one cycle after the last rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      i_r       <= 6'd0;
      x_r       <= 32'sd0;
      y_r       <= 32'sd0;
      z_r       <= 32'sd0;
      x_out     <= 32'd0;
      y_out     <= 32'd0;
      angle_out <= 32'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r      <= x_in;
            y_r      <= y_in;
            z_r      <= angle_in;
            i_r      <= 6'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          if (i_r == ITER_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_r   <= ST_SCALE;
`else
            x_out     <= x_r;
            y_out     <= y_r;
            angle_out <= z_r;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
`endif
          end else begin
            x_r <= x_next_s;
            y_r <= y_next_s;
            z_r <= z_next_s;
            i_r <= i_r + 6'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_SCALE: begin
          x_out     <= gain_scale(x_r);
          y_out     <= gain_scale(y_r);
          angle_out <= z_r;
          out_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          i_r       <= 6'd0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: ideal trig model, latency, backpressure and reset checks.
module tb_cordic_rotator;

  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP = 1'b1;
  localparam int LAT  = ITER + 2;
`else
  localparam bit COMP = 1'b0;
  localparam int LAT  = ITER + 1;
`endif
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] x_in, y_in, angle_in, x_out, y_out, angle_out;

  cordic_rotator #(.ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .angle_out(angle_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint q_ex[$], q_ey[$], q_tol[$], q_stamp[$];
  real    gain;
  longint zbound;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (+-%0d)", name, act, exp, tol);
    end
  endtask

  // Ideal rotation by a*360/2^32 degrees scaled by the expected gain
  function automatic longint model(input longint x, input longint y, input longint a, input bit want_y);
    real th, v;
    th = real'(a) * 2.0 * PI / 4294967296.0;
    if (want_y) v = gain * (real'(x) * $sin(th) + real'(y) * $cos(th));
    else        v = gain * (real'(x) * $cos(th) - real'(y) * $sin(th));
    return longint'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic transact(input longint x, input longint y, input longint a,
                          input longint ex, input longint ey, input longint tol, input int hold);
    int n;
    chk("in_ready_idle", longint'(in_ready), 1, 0);
    x_in = x[31:0]; y_in = y[31:0]; angle_in = a[31:0];
    in_valid = 1'b1;
    tick();
    q_ex.push_back(ex); q_ey.push_back(ey); q_tol.push_back(tol); q_stamp.push_back(cyc);
    chk("busy_rotate", longint'(busy), 1, 0);
    // junk offered while busy must be ignored
    x_in = $urandom; y_in = $urandom; angle_in = $urandom;
    n = 0;
    while (!out_valid && n < LAT + 8) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1, 0);
      q_ex.delete(); q_ey.delete(); q_tol.delete(); q_stamp.delete();
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      chk("in_ready_in_done", longint'(in_ready), 0, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_pop", longint'(in_ready), 1, 0);
    chk("out_valid_after_pop", longint'(out_valid), 0, 0);
  endtask

  // Monitor: latency on rising out_valid, hold stability under backpressure, scoreboard pop on handshake
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] lx, ly, la;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
      pr <= 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (q_ex.size() == 0) chk("unexpected_output", 1, 0, 0);
        else chk("latency", cyc - q_stamp[0], LAT, 0);
      end
      if (out_valid && pv && !pr) begin
        chk("hold_x", longint'(x_out), longint'(lx), 0);
        chk("hold_y", longint'(y_out), longint'(ly), 0);
        chk("hold_angle", longint'(angle_out), longint'(la), 0);
      end
      if (out_valid && out_ready && q_ex.size() > 0) begin
        chk("x_out", longint'($signed(x_out)), q_ex[0], q_tol[0]);
        chk("y_out", longint'($signed(y_out)), q_ey[0], q_tol[0]);
        chk("angle_residual", longint'($signed(angle_out)), 0, zbound);
        void'(q_ex.pop_front()); void'(q_ey.pop_front());
        void'(q_tol.pop_front()); void'(q_stamp.pop_front());
      end
      pv <= out_valid;
      pr <= out_ready;
      lx <= x_out; ly <= y_out; la <= angle_out;
    end
  end

  initial begin
    longint x, y, a;
    bit     seen;
    gain = 1.0;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
    if (COMP) gain = gain * (real'(32'h4DBA76D4) / 2147483648.0);
    zbound = longint'($rtoi(2.0 * $atan(2.0 ** (-(ITER - 1))) / (2.0 * PI) * 4294967296.0)) + 16;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = 32'd0; y_in = 32'd0; angle_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0, 0);
    chk("rst_in_ready", longint'(in_ready), 1, 0);
    chk("rst_busy", longint'(busy), 0, 0);
    chk("rst_x_out", longint'(x_out), 0, 0);
    chk("rst_y_out", longint'(y_out), 0, 0);
    chk("rst_angle_out", longint'(angle_out), 0, 0);
    rst_n = 1'b1;
    tick();

    if (COMP) begin
      transact(1048576, 0, 0, 1048576, 0, 16, 10);
      transact(1048576, 0, 64'sh10000000, 968758, 401273, 32, 2);
      transact(1048576, 0, -64'sh10000000, 968758, -401273, 32, 0);
    end else begin
      transact(1048576, 0, 0, 1726764, 0, 32, 10);
      transact(1048576, 0, 64'sh10000000, model(1048576, 0, 64'sh10000000, 1'b0),
               model(1048576, 0, 64'sh10000000, 1'b1), 128, 2);
    end
    // quadrant-boundary angles
    transact(700000, -300000, 64'sh40000000, model(700000, -300000, 64'sh40000000, 1'b0),
             model(700000, -300000, 64'sh40000000, 1'b1), 128, 1);
    transact(-500000, 800000, -64'sh40000000, model(-500000, 800000, -64'sh40000000, 1'b0),
             model(-500000, 800000, -64'sh40000000, 1'b1), 128, 0);

    for (int t = 0; t < 20; t++) begin
      x = longint'($urandom_range(2097152, 0)) - 1048576;
      y = longint'($urandom_range(2097152, 0)) - 1048576;
      a = longint'($urandom_range(32'h80000000, 0)) - 64'sh40000000;
      transact(x, y, a, model(x, y, a, 1'b0), model(x, y, a, 1'b1), 128, int'($urandom_range(3, 0)));
    end

    // reset during ROTATE discards the result in flight
    x_in = 32'd1048576; y_in = 32'd0; angle_in = 32'h10000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("busy_before_reset", longint'(busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", longint'(out_valid), 0, 0);
    chk("mid_rst_x_out", longint'(x_out), 0, 0);
    chk("mid_rst_y_out", longint'(y_out), 0, 0);
    chk("mid_rst_angle_out", longint'(angle_out), 0, 0);
    chk("mid_rst_busy", longint'(busy), 0, 0);
    chk("mid_rst_in_ready", longint'(in_ready), 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_output", longint'(seen), 0, 0);
    transact(1048576, 0, 64'sh10000000, model(1048576, 0, 64'sh10000000, 1'b0),
             model(1048576, 0, 64'sh10000000, 1'b1), 128, 1);

    repeat (3) tick();
    if (q_ex.size() != 0) chk("scoreboard_drained", longint'(q_ex.size()), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
